datapath_result_checker: RTL and testbench

//  Synthesizable response checker at the output end of the arithmetic datapath. Consumes the

---
 rtl/datapath_result_checker.sv | 146 ++++++++++++++
 tb/tb_datapath_result_checker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_result_checker.sv
// Response checker for the arithmetic datapath. It recomputes the golden
// Y/co from the same operand stream, delays it by the datapath latency,
// compares it with the datapath output and keeps pass/fail statistics.
module datapath_result_checker #(
  parameter int N    = 16,
  parameter int PIPE = 0,
  parameter int CW   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic [2:0]          opcode,
  input  logic signed [N-1:0] dp_y,
  input  logic                dp_co,
  output logic signed [N-1:0] exp_y,
  output logic                exp_co,
  output logic                mismatch,
  output logic                err_sticky,
  output logic [CW-1:0]       chk_count,
  output logic [CW-1:0]       err_count,
  output logic [2:0]          first_err
);

  // Only latencies of 0, 1 or 2 cycles have an alignment path below.
  if ((PIPE < 0) || (PIPE > 2)) begin : g_bad_pipe
    $error("datapath_result_checker: PIPE must be 0, 1 or 2");
  end

  // Golden result packed as {co, y}; co is only meaningful for ADD/SUB.
  function automatic logic [N:0] golden(input logic signed [N-1:0] ga,
                                        input logic signed [N-1:0] gb,
                                        input logic [2:0]          op);
    logic [N:0]          sum;
    logic signed [N-1:0] y;
    logic                co;
    sum = '0;
    y   = '0;
    co  = 1'b0;
    case (op)
      3'b000: begin
        sum = {1'b0, ga} + {1'b0, gb};
        y   = sum[N-1:0];
        co  = sum[N];
      end
      3'b001: begin
        // Carry out of a + ~b + 1: set when no borrow occurs.
        sum = {1'b0, ga} + {1'b0, ~gb} + {{N{1'b0}}, 1'b1};
        y   = sum[N-1:0];
        co  = sum[N];
      end
      3'b010:  y = ga & gb;
      3'b011:  y = ga | gb;
      3'b100:  y = ga ^ gb;
      3'b101:  y = ~ga;
      3'b110:  y = ga <<< 1;
      default: y = ga >>> 1;
    endcase
    return {co, y};
  endfunction

  // Counter increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Stage p0: golden value of the op presented this cycle.
  logic [N:0] gold_p0;
  assign gold_p0 = golden(a, b, opcode);

  // Entry aligned with the datapath output sampled at this edge.
  logic                al_vld;
  logic signed [N-1:0] al_y;
  logic                al_co;
  logic [2:0]          al_op;

  if (PIPE == 0) begin : g_nodly
    assign al_vld = in_valid;
    assign al_y   = gold_p0[N-1:0];
    assign al_co  = gold_p0[N];
    assign al_op  = opcode;
  end else begin : g_dly
    logic                vld_p [PIPE];
    logic signed [N-1:0] y_p   [PIPE];
    logic                co_p  [PIPE];
    logic [2:0]          op_p  [PIPE];

    // Valid bits of the delay line; reset drops every in-flight op.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE; i++) vld_p[i] <= 1'b0;
      end else begin
        vld_p[0] <= in_valid;
        for (int i = 1; i < PIPE; i++) vld_p[i] <= vld_p[i-1];
      end
    end

    // Payload of the delay line; advances every cycle, qualified by vld_p.
    always_ff @(posedge clk) begin
      y_p[0]  <= gold_p0[N-1:0];
      co_p[0] <= gold_p0[N];
      op_p[0] <= opcode;
      for (int i = 1; i < PIPE; i++) begin
        y_p[i]  <= y_p[i-1];
        co_p[i] <= co_p[i-1];
        op_p[i] <= op_p[i-1];
      end
    end

    assign al_vld = vld_p[PIPE-1];
    assign al_y   = y_p[PIPE-1];
    assign al_co  = co_p[PIPE-1];
    assign al_op  = op_p[PIPE-1];
  end

  logic miss;
  assign miss = (al_y != dp_y) || (al_co != dp_co);

  // Compare stage: update expected outputs, counters and error capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_y      <= '0;
      exp_co     <= 1'b0;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      chk_count  <= '0;
      err_count  <= '0;
      first_err  <= '0;
    end else begin
      mismatch <= 1'b0;
      if (al_vld) begin
        exp_y     <= al_y;
        exp_co    <= al_co;
        chk_count <= sat_inc(chk_count);
        if (miss) begin
          mismatch   <= 1'b1;
          err_count  <= sat_inc(err_count);
          err_sticky <= 1'b1;
          if (!err_sticky) first_err <= al_op;
        end
      end
    end
  end

endmodule

// File: tb/tb_datapath_result_checker.sv
// Directed bench for datapath_result_checker across PIPE=0/1/2 and a
// narrow-counter instance.
module tb_datapath_result_checker;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] a, b;
  logic [2:0]         opcode;
  logic signed [15:0] dpy [4];
  logic               dpco [4];
  logic signed [15:0] ey [4];
  logic               eco [4];
  logic               mm [4];
  logic               st [4];
  logic [2:0]         fe [4];
  logic [15:0]        cc [3];
  logic [15:0]        ec [3];
  logic [2:0]         cc3, ec3;

  logic [15:0] y_t [8];
  logic        co_t [8];

  int n_cmp = 0;
  int n_err = 0;

  datapath_result_checker #(.N(16), .PIPE(0), .CW(16)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .opcode(opcode),
    .dp_y(dpy[0]), .dp_co(dpco[0]), .exp_y(ey[0]), .exp_co(eco[0]), .mismatch(mm[0]),
    .err_sticky(st[0]), .chk_count(cc[0]), .err_count(ec[0]), .first_err(fe[0]));

  datapath_result_checker #(.N(16), .PIPE(1), .CW(16)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .opcode(opcode),
    .dp_y(dpy[1]), .dp_co(dpco[1]), .exp_y(ey[1]), .exp_co(eco[1]), .mismatch(mm[1]),
    .err_sticky(st[1]), .chk_count(cc[1]), .err_count(ec[1]), .first_err(fe[1]));

  datapath_result_checker #(.N(16), .PIPE(2), .CW(16)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .opcode(opcode),
    .dp_y(dpy[2]), .dp_co(dpco[2]), .exp_y(ey[2]), .exp_co(eco[2]), .mismatch(mm[2]),
    .err_sticky(st[2]), .chk_count(cc[2]), .err_count(ec[2]), .first_err(fe[2]));

  datapath_result_checker #(.N(16), .PIPE(0), .CW(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .opcode(opcode),
    .dp_y(dpy[3]), .dp_co(dpco[3]), .exp_y(ey[3]), .exp_co(eco[3]), .mismatch(mm[3]),
    .err_sticky(st[3]), .chk_count(cc3), .err_count(ec3), .first_err(fe[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    opcode   = 3'd0;
    a        = 16'sd5;
    b        = 16'sd7;
    for (int k = 0; k < 4; k++) begin
      dpy[k]  = 16'hdead;
      dpco[k] = 1'b0;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (cc[k] !== 16'd0) begin n_err++; $display("FAIL reset_chk[%0d]: got %0d want 0", k, cc[k]); end
      n_cmp++; if (ec[k] !== 16'd0) begin n_err++; $display("FAIL reset_err[%0d]: got %0d want 0", k, ec[k]); end
      n_cmp++; if ({mm[k], st[k], eco[k], fe[k]} !== 6'd0) begin n_err++;
        $display("FAIL reset_flags[%0d]: got mm=%b st=%b co=%b fe=%0d want all 0", k, mm[k], st[k], eco[k], fe[k]); end
      n_cmp++; if (ey[k] !== 16'sd0) begin n_err++; $display("FAIL reset_expy[%0d]: got %h want 0", k, ey[k]); end
    end
    n_cmp++; if ({cc3, ec3, mm[3], st[3]} !== 8'd0) begin n_err++;
      $display("FAIL reset_cw3: got chk=%0d err=%0d mm=%b st=%b want 0", cc3, ec3, mm[3], st[3]); end
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_add_pipe0;
    do_reset();
    in_valid = 1'b1; opcode = 3'd0; a = 16'sd5; b = -16'sd3;
    dpy[0] = 16'sd2; dpco[0] = 1'b1;
    tick();
    n_cmp++; if (mm[0] !== 1'b0) begin n_err++; $display("FAIL add_mm: got %b want 0", mm[0]); end
    n_cmp++; if (cc[0] !== 16'd1) begin n_err++; $display("FAIL add_chk: got %0d want 1", cc[0]); end
    n_cmp++; if (ey[0] !== 16'sd2) begin n_err++; $display("FAIL add_expy: got %h want 0002", ey[0]); end
    n_cmp++; if (eco[0] !== 1'b1) begin n_err++; $display("FAIL add_expco: got %b want 1", eco[0]); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (cc[0] !== 16'd1) begin n_err++; $display("FAIL add_bubble_hold: got %0d want 1", cc[0]); end
    in_valid = 1'b1; dpco[0] = 1'b0;
    tick();
    n_cmp++; if (mm[0] !== 1'b1) begin n_err++; $display("FAIL add_co_fault_mm: got %b want 1", mm[0]); end
    n_cmp++; if (ec[0] !== 16'd1) begin n_err++; $display("FAIL add_co_fault_err: got %0d want 1", ec[0]); end
    n_cmp++; if (st[0] !== 1'b1) begin n_err++; $display("FAIL add_co_fault_sticky: got %b want 1", st[0]); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (mm[0] !== 1'b0) begin n_err++; $display("FAIL add_mm_pulse: got %b want 0", mm[0]); end
  endtask

  task automatic test_sub_pipe2;
    do_reset();
    in_valid = 1'b1; opcode = 3'd1; a = -16'sd32768; b = 16'sd1;
    dpy[2] = 16'h1111; dpco[2] = 1'b0;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (cc[2] !== 16'd0) begin n_err++; $display("FAIL sub_early0: got %0d want 0", cc[2]); end
    tick();
    n_cmp++; if (cc[2] !== 16'd0) begin n_err++; $display("FAIL sub_early1: got %0d want 0", cc[2]); end
    dpy[2] = 16'sd0; dpco[2] = 1'b1;
    tick();
    n_cmp++; if (cc[2] !== 16'd1) begin n_err++; $display("FAIL sub_chk: got %0d want 1", cc[2]); end
    n_cmp++; if (ey[2] !== 16'sd32767) begin n_err++; $display("FAIL sub_expy: got %h want 7fff", ey[2]); end
    n_cmp++; if (eco[2] !== 1'b1) begin n_err++; $display("FAIL sub_expco: got %b want 1", eco[2]); end
    n_cmp++; if (mm[2] !== 1'b1) begin n_err++; $display("FAIL sub_mm: got %b want 1", mm[2]); end
    n_cmp++; if (ec[2] !== 16'd1) begin n_err++; $display("FAIL sub_err: got %0d want 1", ec[2]); end
    n_cmp++; if (fe[2] !== 3'b001) begin n_err++; $display("FAIL sub_first: got %b want 001", fe[2]); end
    tick();
    n_cmp++; if (mm[2] !== 1'b0) begin n_err++; $display("FAIL sub_pulse: got %b want 0", mm[2]); end
    n_cmp++; if (st[2] !== 1'b1) begin n_err++; $display("FAIL sub_sticky: got %b want 1", st[2]); end
  endtask

  task automatic test_alternate_pipe1;
    logic [2:0]  ops [4];
    logic [15:0] res [4];
    ops = '{3'd2, 3'd3, 3'd4, 3'd0};
    res = '{16'h0034, 16'h12ff, 16'h12cb, 16'h1333};
    do_reset();
    a = 16'sh1234; b = 16'sh00ff;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        in_valid = 1'b1; opcode = ops[i/2];
        dpy[1] = 16'hbeef; dpco[1] = 1'b1;
      end else begin
        in_valid = 1'b0;
        dpy[1] = res[i/2]; dpco[1] = 1'b0;
      end
      tick();
      n_cmp++; if (mm[1] !== 1'b0) begin n_err++; $display("FAIL alt_mm[%0d]: got %b want 0", i, mm[1]); end
    end
    n_cmp++; if (cc[1] !== 16'd4) begin n_err++; $display("FAIL alt_chk: got %0d want 4", cc[1]); end
    n_cmp++; if (ec[1] !== 16'd0) begin n_err++; $display("FAIL alt_err: got %0d want 0", ec[1]); end
    n_cmp++; if (ey[1] !== 16'sh1333) begin n_err++; $display("FAIL alt_expy: got %h want 1333", ey[1]); end
    n_cmp++; if (eco[1] !== 1'b0) begin n_err++; $display("FAIL alt_expco: got %b want 0", eco[1]); end
  endtask

  task automatic test_reset_flush_pipe2;
    do_reset();
    in_valid = 1'b1; opcode = 3'd0; a = 16'sd1; b = 16'sd1;
    dpy[2] = 16'h5555; dpco[2] = 1'b1;
    tick();
    tick();
    rst_n = 1'b0; in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if ({cc[2], ec[2]} !== 32'd0) begin n_err++; $display("FAIL flush_cnt0: got chk=%0d err=%0d want 0", cc[2], ec[2]); end
    tick();
    n_cmp++; if ({cc[2], st[2]} !== 17'd0) begin n_err++; $display("FAIL flush_cnt1: got chk=%0d st=%b want 0", cc[2], st[2]); end
    in_valid = 1'b1; opcode = 3'd3; a = 16'sd3; b = 16'sd5;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (cc[2] !== 16'd0) begin n_err++; $display("FAIL flush_next_early: got %0d want 0", cc[2]); end
    dpy[2] = 16'sd7; dpco[2] = 1'b0;
    tick();
    n_cmp++; if (cc[2] !== 16'd1) begin n_err++; $display("FAIL flush_next_chk: got %0d want 1", cc[2]); end
    n_cmp++; if (mm[2] !== 1'b0) begin n_err++; $display("FAIL flush_next_mm: got %b want 0", mm[2]); end
    n_cmp++; if (ey[2] !== 16'sd7) begin n_err++; $display("FAIL flush_next_expy: got %h want 0007", ey[2]); end
  endtask

  task automatic test_saturate_cw3;
    logic [2:0] want;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1; a = 16'sd0; b = 16'sd0; dpco[3] = 1'b0;
      if (i == 1) begin opcode = 3'd5; dpy[3] = 16'sd0; end
      else        begin opcode = 3'd0; dpy[3] = 16'sd1; end
      tick();
      want = (i > 7) ? 3'd7 : 3'(i);
      n_cmp++; if (cc3 !== want) begin n_err++; $display("FAIL sat_chk[%0d]: got %0d want %0d", i, cc3, want); end
      n_cmp++; if (ec3 !== want) begin n_err++; $display("FAIL sat_err[%0d]: got %0d want %0d", i, ec3, want); end
      n_cmp++; if (mm[3] !== 1'b1) begin n_err++; $display("FAIL sat_mm[%0d]: got %b want 1", i, mm[3]); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (fe[3] !== 3'd5) begin n_err++; $display("FAIL sat_first: got %0d want 5", fe[3]); end
    n_cmp++; if (st[3] !== 1'b1) begin n_err++; $display("FAIL sat_sticky: got %b want 1", st[3]); end
    n_cmp++; if ({ey[3], eco[3]} !== 17'd0) begin n_err++; $display("FAIL sat_exp: got y=%h co=%b want 0", ey[3], eco[3]); end
  endtask

  task automatic test_sweep_pipe0;
    do_reset();
    a = 16'sd32767; b = 16'sd32767;
    for (int op = 0; op < 8; op++) begin
      in_valid = 1'b1; opcode = 3'(op);
      dpy[0] = y_t[op]; dpco[0] = co_t[op];
      tick();
      n_cmp++; if (mm[0] !== 1'b0) begin n_err++; $display("FAIL sweep_mm[%0d]: got %b want 0", op, mm[0]); end
      n_cmp++; if (ey[0] !== y_t[op]) begin n_err++; $display("FAIL sweep_expy[%0d]: got %h want %h", op, ey[0], y_t[op]); end
      n_cmp++; if (eco[0] !== co_t[op]) begin n_err++; $display("FAIL sweep_expco[%0d]: got %b want %b", op, eco[0], co_t[op]); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (cc[0] !== 16'd8) begin n_err++; $display("FAIL sweep_chk: got %0d want 8", cc[0]); end
    n_cmp++; if (ec[0] !== 16'd0) begin n_err++; $display("FAIL sweep_err: got %0d want 0", ec[0]); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    a = 16'sd32767; b = 16'sd32767;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      opcode   = 3'(i);
      if (i >= 2) begin dpy[2] = y_t[i-2]; dpco[2] = co_t[i-2]; end
      else        begin dpy[2] = 16'h0bad; dpco[2] = 1'b1; end
      tick();
      if (i >= 2) begin
        n_cmp++; if (mm[2] !== 1'b0) begin n_err++; $display("FAIL b2b_mm[%0d]: got %b want 0", i, mm[2]); end
        n_cmp++; if (ey[2] !== y_t[i-2]) begin n_err++; $display("FAIL b2b_expy[%0d]: got %h want %h", i, ey[2], y_t[i-2]); end
      end else begin
        n_cmp++; if (cc[2] !== 16'd0) begin n_err++; $display("FAIL b2b_early[%0d]: got %0d want 0", i, cc[2]); end
      end
    end
    n_cmp++; if (cc[2] !== 16'd8) begin n_err++; $display("FAIL b2b_chk: got %0d want 8", cc[2]); end
    n_cmp++; if (ec[2] !== 16'd0) begin n_err++; $display("FAIL b2b_err: got %0d want 0", ec[2]); end
    n_cmp++; if ({fe[1], fe[2]} !== 6'd0) begin n_err++; $display("FAIL b2b_first: got %0d/%0d want 0", fe[1], fe[2]); end
  endtask

  initial begin
    // Hand-computed results for a = b = 32767 (0x7fff), opcodes 000..111.
    y_t  = '{16'hfffe, 16'h0000, 16'h7fff, 16'h7fff, 16'h0000, 16'h8000, 16'hfffe, 16'h3fff};
    co_t = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rst_n = 1'b0; in_valid = 1'b0; opcode = 3'd0; a = '0; b = '0;
    for (int k = 0; k < 4; k++) begin dpy[k] = '0; dpco[k] = 1'b0; end
    test_reset();
    test_add_pipe0();
    test_sub_pipe2();
    test_alternate_pipe1();
    test_reset_flush_pipe2();
    test_saturate_cw3();
    test_sweep_pipe0();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
